// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/WB side bundle between pipeline and register scoreboard
interface reg_scoreboard_if #(
  parameter int NREG = 32
);
  logic            id_valid;
  logic            ex_allow;
  logic [4:0]      id_rj;
  logic            id_rj_used;
  logic [4:0]      id_rk;
  logic            id_rk_used;
  logic            id_rf_we;
  logic [4:0]      id_dest;
  logic            wb_valid;
  logic            wb_rf_we;
  logic [4:0]      wb_dest;
  logic            flush;
  logic            id_stall;
  logic            id_issue;
  logic [NREG-1:0] pend_mask;
  logic            sb_err;

  modport master (
    output id_valid, ex_allow, id_rj, id_rj_used, id_rk, id_rk_used,
           id_rf_we, id_dest, wb_valid, wb_rf_we, wb_dest, flush,
    input  id_stall, id_issue, pend_mask, sb_err
  );

  modport slave (
    input  id_valid, ex_allow, id_rj, id_rj_used, id_rk, id_rk_used,
           id_rf_we, id_dest, wb_valid, wb_rf_we, wb_dest, flush,
    output id_stall, id_issue, pend_mask, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-GPR pending-write counters driving the ID-stage stall
module reg_scoreboard #(
  parameter int NREG     = 32,
  parameter int CNT_W    = 2,
  parameter int MAX_PEND = 3
) (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q;
  logic             sb_err_d;

  logic haz_rj;
  logic haz_rk;
  logic haz_full;
  logic stall;
  logic issue;
  logic inc;
  logic dec;

  // Hazard detection and issue; stall is kept independent of ex_allow to avoid a loop with allow_3
  always_comb begin
    haz_rj   = sb.id_rj_used && (sb.id_rj != 5'd0) && (cnt_q[sb.id_rj] != '0);
    haz_rk   = sb.id_rk_used && (sb.id_rk != 5'd0) && (cnt_q[sb.id_rk] != '0);
    haz_full = sb.id_rf_we && (sb.id_dest != 5'd0) && (cnt_q[sb.id_dest] == MAX_CNT);
    stall    = sb.id_valid && (haz_rj || haz_rk || haz_full);
    issue    = sb.id_valid && sb.ex_allow && !stall;
    inc      = issue && sb.id_rf_we && (sb.id_dest != 5'd0);
    dec      = sb.wb_valid && sb.wb_rf_we && (sb.wb_dest != 5'd0);
  end

  // Counter next state: flush clears all, same-register inc+dec cancels, retire on empty flags sb_err
  always_comb begin
    sb_err_d = sb_err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (sb.flush) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc && (sb.id_dest == 5'(i)) && !(dec && (sb.wb_dest == 5'(i)))) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (dec && (sb.wb_dest == 5'(i)) && !(inc && (sb.id_dest == 5'(i)))) begin
          if (cnt_q[i] == '0) begin
            sb_err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // State register: reset clears counters and the sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Outputs: pending mask from counters, register 0 always reported clear
  always_comb begin
    sb.pend_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      sb.pend_mask[i] = (cnt_q[i] != '0);
    end
    sb.id_stall = stall;
    sb.id_issue = issue;
    sb.sb_err   = sb_err_q;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench for reg_scoreboard with directed and random traffic
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(32)) intf ();

  reg_scoreboard #(.NREG(32), .CNT_W(2), .MAX_PEND(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (intf.slave)
  );

  typedef struct {
    logic        stall;
    logic        issue;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Reference model: number of writes in flight per register, plus sticky error
  int pend[32];
  bit m_err;

  task automatic cyc(input logic v, input logic ea,
                     input logic [4:0] rj, input logic rju,
                     input logic [4:0] rk, input logic rku,
                     input logic we, input logic [4:0] dest,
                     input logic wv, input logic wwe, input logic [4:0] wd,
                     input logic fl, input logic rst);
    exp_t e;
    bit   hz;
    bit   inc_m;
    bit   dec_m;
    @(negedge clk);
    #1;
    reset           = rst;
    intf.id_valid   = v;
    intf.ex_allow   = ea;
    intf.id_rj      = rj;
    intf.id_rj_used = rju;
    intf.id_rk      = rk;
    intf.id_rk_used = rku;
    intf.id_rf_we   = we;
    intf.id_dest    = dest;
    intf.wb_valid   = wv;
    intf.wb_rf_we   = wwe;
    intf.wb_dest    = wd;
    intf.flush      = fl;
    // An instruction waits if it reads a register with a write in flight,
    // or if its destination already has three writes in flight.
    hz = (rju && rj != 0 && pend[rj] > 0) ||
         (rku && rk != 0 && pend[rk] > 0) ||
         (we && dest != 0 && pend[dest] >= 3);
    e.stall = v && hz;
    e.issue = v && ea && !hz;
    e.mask  = '0;
    for (int i = 1; i < 32; i++) e.mask[i] = (pend[i] > 0);
    e.err = m_err;
    exp_q.push_back(e);
    inc_m = e.issue && we && dest != 0;
    dec_m = wv && wwe && wd != 0;
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      m_err = 0;
    end else if (fl) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else if (!(inc_m && dec_m && dest == wd)) begin
      if (inc_m) pend[dest] = pend[dest] + 1;
      if (dec_m) begin
        if (pend[wd] == 0) m_err = 1;
        else pend[wd] = pend[wd] - 1;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] d);
    cyc(1, 1, 0, 0, 0, 0, 1, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rt(input logic [4:0] d);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, d, 0, 0);
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (intf.id_stall !== e.stall) begin
          errors++;
          $display("FAIL id_stall actual=%b expected=%b t=%0t", intf.id_stall, e.stall, $time);
        end
        checks++;
        if (intf.id_issue !== e.issue) begin
          errors++;
          $display("FAIL id_issue actual=%b expected=%b t=%0t", intf.id_issue, e.issue, $time);
        end
        checks++;
        if (intf.pend_mask !== e.mask) begin
          errors++;
          $display("FAIL pend_mask actual=%h expected=%h t=%0t", intf.pend_mask, e.mask, $time);
        end
        checks++;
        if (intf.sb_err !== e.err) begin
          errors++;
          $display("FAIL sb_err actual=%b expected=%b t=%0t", intf.sb_err, e.err, $time);
        end
      end
    end
  end

  initial begin
    int cand[$];
    logic [4:0] wd;
    intf.id_valid = 0; intf.ex_allow = 0; intf.id_rj = 0; intf.id_rj_used = 0;
    intf.id_rk = 0; intf.id_rk_used = 0; intf.id_rf_we = 0; intf.id_dest = 0;
    intf.wb_valid = 0; intf.wb_rf_we = 0; intf.wb_dest = 0; intf.flush = 0;
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_err = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state: reader of r5 issues, nothing pending
    cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 1/2: add r5 issues, addi r6,r5 stalls until one cycle after WB retires r5
    wr(5);
    cyc(1, 1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 0, 0, 1, 6, 1, 1, 5, 0, 0);
    cyc(1, 1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    rt(6);
    // 3: same-cycle issue and retire on r7 leaves the count at 1
    wr(7);
    cyc(1, 1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0, 0);
    cyc(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rt(7);
    cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    // 4: bl with r4 pending does not read rj; r1 becomes pending
    wr(4);
    cyc(1, 1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    rt(4);
    rt(1);
    // 5: fourth in-flight write to r9 waits for the first retire
    wr(9); wr(9); wr(9);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    rt(9); rt(9); rt(9);
    // Register 0 never counts and never stalls; ex_allow low blocks issue but not stall
    cyc(1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    wr(2);
    cyc(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    rt(2);
    // 6: flush drops r3 and r8, a later retire to r3 is an error until reset
    wr(3); wr(8);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rt(3);
    idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 500; n++) begin
      cand.delete();
      for (int i = 1; i < 8; i++) if (pend[i] > 0) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8)
        wd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wd = 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
          $urandom_range(0, 9) < 4, $urandom_range(0, 5) != 0, wd,
          $urandom_range(0, 63) == 0, n == 250);
    end
    idle();
    stim_done = 1;
  end

  initial begin
    wait (stim_done == 1 || $time > 200000);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || stim_done != 1) begin
      errors++;
      $display("FAIL drain pending=%0d done=%0d expected pending=0 done=1", exp_q.size(), stim_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
